sprite_cat_ctrl: RTL and testbench
==================================

# sprite_cat_ctrl

Per-frame motion and animation controller for the cat sprite renderer in the `clk_pix` domain. It watches the raster position (`sx`, `sy`) and detects one frame tick per frame at the start of vertical blanking. On each tick it updates the sprite's top-left position (`cat_x`, `cat_y`), facing direction and walk-cycle frame index, so the renderer only ever sees values that are stable for a whole visible frame. Motion is an automatic left/right patrol that bounces off the screen edges, plus a button-triggered jump (rise, then fall back to ground), with a pause input that freezes all motion.

## Interface
Parameters:
- `X_MIN`, 0: left limit for `cat_x`.
- `X_MAX`, 640: right screen edge (exclusive); `cat_x` never exceeds `X_MAX-SPRITE_W`.
- `SPRITE_W`, 32: sprite width in pixels.
- `X_START`, 272: `cat_x` after reset.
- `GROUND_Y`, 220: resting `cat_y`.
- `WALK_SPD`, 2: horizontal pixels moved per tick.
- `JUMP_SPD`, 4: vertical pixels moved per tick while in the air.
- `JUMP_H`, 40: apex height above ground.
- `ANIM_DIV`, 8: walking ticks per animation frame step.
- `V_TICK`, 480: `sy` row that generates the tick (first blanking line).

Ports:
- `clk_pix` in 1: pixel clock, the only clock.
- `rst_pix_n` in 1: reset, asynchronous assert, active-low.
- `sx` in 10: raster column.
- `sy` in 9: raster row.
- `btn_jump` in 1: raw asynchronous jump button, active-high.
- `pause` in 1: level input; when high, ticks cause no updates.
- `cat_x` out 10: sprite left column.
- `cat_y` out 9: sprite top row.
- `dir` out 1: facing direction, 1 = right, 0 = left.
- `frame_idx` out 2: walk-cycle frame, 0 to 3.
- `airborne` out 1: high in the RISE and FALL states.
- `frame_tick` out 1: one-cycle pulse, registered.

## Operation
- **Tick condition:** the sampled inputs satisfy `sx==0 && sy==V_TICK`. Exactly one tick occurs per frame.
- **Button path:** `btn_jump` passes through a 2-flop synchronizer and then a rising-edge detector. A detected edge sets `jump_pend`.
- **Clearing `jump_pend`:** it is cleared on any non-paused tick. If that tick finds the FSM in WALK, the jump is consumed; in RISE or FALL the request is discarded. A paused tick does not clear it.
- **States:** WALK, RISE, FALL.
  - WALK: if `jump_pend`, move to RISE and apply the first rise step on the same tick. Otherwise stay in WALK.
  - RISE: compute `cat_y -= JUMP_SPD`. When the result is at or below `GROUND_Y-JUMP_H`, clamp `cat_y` to `GROUND_Y-JUMP_H` and move to FALL.
  - FALL: compute `cat_y += JUMP_SPD`. When the result is at or above `GROUND_Y`, clamp `cat_y` to `GROUND_Y` and move to WALK.
- **Horizontal motion (every non-paused tick, all states):**
  - `dir`=1: next x = `cat_x+WALK_SPD`. If that is at or above `X_MAX-SPRITE_W`, clamp to `X_MAX-SPRITE_W` and set `dir`=0.
  - `dir`=0: if `cat_x` is at or below `X_MIN+WALK_SPD`, clamp to `X_MIN` and set `dir`=1; otherwise `cat_x -= WALK_SPD`.
  - All comparisons use 11-bit unsigned arithmetic, so no wrap is possible.
- **Animation:**
  - In WALK, a frame counter counts non-paused ticks. When it reaches `ANIM_DIV-1` it resets to 0 and `frame_idx` increments, wrapping from 3 to 0.
  - In RISE and FALL, both `frame_idx` and the counter hold.
- **Pause:** `frame_tick` still pulses. Position, `dir`, state, `frame_idx` and the anim counter all hold. A pending jump stays latched.

## Timing
- **Reset values:**
  - `cat_x`=`X_START`, `cat_y`=`GROUND_Y`.
  - `dir`=1, state=WALK, `airborne`=0.
  - `frame_idx`=0, anim counter=0.
  - `frame_tick`=0, `jump_pend`=0, synchronizer flops=0.
- **Update latency:** all state registers update on the same rising edge that samples the tick condition. `frame_tick` is high for the cycle after that edge, and outputs are valid from that edge.
- **Button latency:** a button edge sets `jump_pend` 3 `clk_pix` edges after it meets setup at the first flop.
- **Simultaneous events:**
  - If an edge detect and a tick fall on the same edge, the tick sees the old `jump_pend` value. The new edge is then cleared by that tick, so it is lost only if the tick is non-paused.
  - Making that rule bench-visible: a press landing on the tick edge is dropped.
- **Reset mid-jump:** returns immediately to the reset values; no partial fall.
- **Output behaviour between ticks:** outputs are constant.

## Structure
- **Shared package `cat_pkg`:**
  - state encoding: WALK=2'd0, RISE=2'd1, FALL=2'd2.
  - screen constants: H_RES=640, V_RES=480.
  - `SPRITE_W`, `SPRITE_H`=20.
- **Sub-module `btn_sync_edge`:** 2-flop synchronizer plus rising-edge pulse, with `clk_pix` and `rst_pix_n`. It is reused for future buttons.
- **Integration:** the renderer consumes `cat_x`/`cat_y` in place of its fixed origin.

## Test plan
- **Reset and walk:** release reset and drive 1 tick → `cat_x`=274, `cat_y`=220, `dir`=1, `frame_idx`=0. After 8 ticks → `frame_idx`=1, `cat_x`=288.
- **Right bounce:** run 168 ticks from reset → `cat_x`=608, `dir`=0. Next tick → `cat_x`=606.
- **Left bounce:** force the patrol toward `X_MIN`; with `cat_x`=2 and `dir`=0, one tick → `cat_x`=0, `dir`=1. Next tick → 2.
- **Jump:** pulse `btn_jump` in WALK, then ticks follow:
  - tick 1: RISE, `cat_y`=216, `airborne`=1.
  - tick 10: `cat_y`=180, FALL.
  - tick 20: `cat_y`=220, WALK, `airborne`=0.
  - `frame_idx` is frozen throughout.
  - A second press during RISE causes no re-jump after landing.
- **Pause:** hold `pause` for 5 ticks with a jump pressed → `frame_tick` pulses 5 times and all outputs are unchanged. On the first tick after release → RISE begins.
- **Async reset mid-FALL:** assert `rst_pix_n` low between clock edges → outputs reach their reset values immediately without a clock. After release, `frame_tick` stays 0 until the next tick condition.

Source files
------------

// File: rtl/cat_pkg.sv
// Shared definitions for the cat sprite blocks: controller state encoding
// and the screen / sprite geometry the renderer is built around.
package cat_pkg;

  typedef enum logic [1:0] {
    WALK = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2
  } cat_state_e;

  localparam int H_RES    = 640;
  localparam int V_RES    = 480;
  localparam int SPRITE_W = 32;
  localparam int SPRITE_H = 20;

  // Zero-extend a 10-bit coordinate into the 11-bit working width so that
  // adding a step can never wrap back onto the screen.
  function automatic logic [10:0] ext11(input logic [9:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw asynchronous button, followed by a
// rising-edge detector. The pulse is one clk_pix cycle wide and appears
// on the second edge after the input meets setup at the first flop.
module btn_sync_edge (
  input  logic clk_pix,
  input  logic rst_pix_n,
  input  logic btn_async,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Shift the button through the synchronizer and keep one delayed copy.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the value from before the edge, giving a true shift register.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn_async;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/sprite_cat_ctrl.sv
// Per-frame motion and animation controller for the cat sprite. Once per
// frame, at the first blanking line, it advances the left/right patrol, the
// jump state machine and the walk-cycle frame, so the renderer sees values
// that stay constant across a whole visible frame.
module sprite_cat_ctrl #(
  parameter int X_MIN    = 0,
  parameter int X_MAX    = cat_pkg::H_RES,
  parameter int SPRITE_W = cat_pkg::SPRITE_W,
  parameter int X_START  = 272,
  parameter int GROUND_Y = 220,
  parameter int WALK_SPD = 2,
  parameter int JUMP_SPD = 4,
  parameter int JUMP_H   = 40,
  parameter int ANIM_DIV = 8,
  parameter int V_TICK   = 480
) (
  input  logic       clk_pix,
  input  logic       rst_pix_n,
  input  logic [9:0] sx,
  input  logic [8:0] sy,
  input  logic       btn_jump,
  input  logic       pause,
  output logic [9:0] cat_x,
  output logic [8:0] cat_y,
  output logic       dir,
  output logic [1:0] frame_idx,
  output logic       airborne,
  output logic       frame_tick
);

  import cat_pkg::*;

  // Motion limits and steps in the 11-bit working width.
  localparam logic [10:0] X_RIGHT = 11'(X_MAX - SPRITE_W);
  localparam logic [10:0] X_LEFT  = 11'(X_MIN);
  localparam logic [10:0] X_TURN  = 11'(X_MIN + WALK_SPD);
  localparam logic [10:0] STEP_X  = 11'(WALK_SPD);
  localparam logic [10:0] STEP_Y  = 11'(JUMP_SPD);
  localparam logic [10:0] Y_TOP   = 11'(GROUND_Y - JUMP_H);
  localparam logic [10:0] Y_GND   = 11'(GROUND_Y);

  localparam int              CNT_W     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CNT_W-1:0] ANIM_LAST = CNT_W'(ANIM_DIV - 1);

  cat_state_e       state_q, state_d;
  logic [9:0]       x_q, x_d;
  logic [8:0]       y_q, y_d;
  logic             dir_q, dir_d;
  logic [1:0]       frame_q, frame_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             jump_pend_q, jump_pend_d;
  logic             frame_tick_q;

  logic             tick_cond;
  logic             upd;
  logic             jump_edge;
  logic             do_rise;
  logic [10:0]      x_ext;
  logic [10:0]      y_ext;
  logic [10:0]      right_x;
  logic [10:0]      rise_y;
  logic [10:0]      fall_y;

  btn_sync_edge u_btn_jump (
    .clk_pix   (clk_pix),
    .rst_pix_n (rst_pix_n),
    .btn_async (btn_jump),
    .rise      (jump_edge)
  );

  assign tick_cond = (sx == 10'd0) && (sy == 9'(V_TICK));
  assign upd       = tick_cond && !pause;

  // State register for the FSM, position, animation and the jump request.
  // NOTE: every register, including the anim counter and the pending jump,
  // is reset so behaviour after an asynchronous reset is fully defined.
  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state_q      <= WALK;
      x_q          <= 10'(X_START);
      y_q          <= 9'(GROUND_Y);
      dir_q        <= 1'b1;
      frame_q      <= 2'd0;
      cnt_q        <= '0;
      jump_pend_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_q        <= dir_d;
      frame_q      <= frame_d;
      cnt_q        <= cnt_d;
      jump_pend_q  <= jump_pend_d;
      frame_tick_q <= tick_cond;
    end
  end

  // Next-state logic: everything holds unless a non-paused tick arrives.
  always_comb begin
    // NOTE: every variable gets a hold value first so no path through the
    // block leaves it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_d       = dir_q;
    frame_d     = frame_q;
    cnt_d       = cnt_q;
    jump_pend_d = jump_pend_q;
    do_rise     = 1'b0;

    x_ext   = ext11(x_q);
    y_ext   = {2'b00, y_q};
    right_x = x_ext + STEP_X;
    rise_y  = y_ext - STEP_Y;
    fall_y  = y_ext + STEP_Y;

    // A tick consumes or discards the request; a press on that same edge
    // is therefore lost, while a paused tick leaves the request latched.
    if (upd) begin
      jump_pend_d = 1'b0;
    end else if (jump_edge) begin
      jump_pend_d = 1'b1;
    end

    if (upd) begin
      // Horizontal patrol, bouncing off both edges.
      if (dir_q) begin
        if (right_x >= X_RIGHT) begin
          x_d   = X_RIGHT[9:0];
          dir_d = 1'b0;
        end else begin
          x_d = right_x[9:0];
        end
      end else begin
        if (x_ext <= X_TURN) begin
          x_d   = X_LEFT[9:0];
          dir_d = 1'b1;
        end else begin
          x_d = 10'(x_ext - STEP_X);
        end
      end

      unique case (state_q)
        WALK: begin
          if (cnt_q == ANIM_LAST) begin
            cnt_d   = '0;
            frame_d = frame_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (jump_pend_q) do_rise = 1'b1;
        end
        RISE: do_rise = 1'b1;
        FALL: begin
          if (fall_y >= Y_GND) begin
            y_d     = Y_GND[8:0];
            state_d = WALK;
          end else begin
            y_d = fall_y[8:0];
          end
        end
        default: state_d = WALK;
      endcase

      // Rising step, shared by the take-off tick and the RISE state.
      if (do_rise) begin
        if (rise_y <= Y_TOP) begin
          y_d     = Y_TOP[8:0];
          state_d = FALL;
        end else begin
          y_d     = rise_y[8:0];
          state_d = RISE;
        end
      end
    end
  end

  assign cat_x      = x_q;
  assign cat_y      = y_q;
  assign dir        = dir_q;
  assign frame_idx  = frame_q;
  assign airborne   = (state_q == RISE) || (state_q == FALL);
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sprite_cat_ctrl.sv
// Scoreboard bench for sprite_cat_ctrl. Each issued tick pushes the
// hand-computed outputs expected after it; a monitor pops one entry per
// frame_tick pulse and compares.
module tb_sprite_cat_ctrl;

  logic       clk_pix   = 1'b0;
  logic       rst_pix_n = 1'b0;
  logic [9:0] sx        = 10'd5;
  logic [8:0] sy        = 9'd100;
  logic       btn_jump  = 1'b0;
  logic       pause     = 1'b0;
  logic [9:0] cat_x;
  logic [8:0] cat_y;
  logic       dir;
  logic [1:0] frame_idx;
  logic       airborne;
  logic       frame_tick;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    bit chk;
    int x;
    int y;
    int dir;
    int frame;
    int air;
  } exp_t;

  exp_t sb[$];

  sprite_cat_ctrl dut (
    .clk_pix    (clk_pix),
    .rst_pix_n  (rst_pix_n),
    .sx         (sx),
    .sy         (sy),
    .btn_jump   (btn_jump),
    .pause      (pause),
    .cat_x      (cat_x),
    .cat_y      (cat_y),
    .dir        (dir),
    .frame_idx  (frame_idx),
    .airborne   (airborne),
    .frame_tick (frame_tick)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Present one tick condition for a single cycle and queue its expectation.
  task automatic tick(input bit chk, input int x, input int y, input int d,
                      input int f, input int a);
    exp_t e;
    @(negedge clk_pix);
    sx = 10'd0;
    sy = 9'd480;
    e.chk = chk; e.x = x; e.y = y; e.dir = d; e.frame = f; e.air = a;
    sb.push_back(e);
    @(negedge clk_pix);
    sx = 10'd5;
    sy = 9'd100;
  endtask

  task automatic tick_nc();
    tick(1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic press();
    @(negedge clk_pix);
    btn_jump = 1'b1;
    repeat (4) @(negedge clk_pix);
    btn_jump = 1'b0;
    repeat (4) @(negedge clk_pix);
  endtask

  // Wait, bounded, for every queued expectation to be matched by a pulse.
  task automatic drain(input string name);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk_pix);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s missing_pulses actual=%0d expected=0", name, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: one scoreboard entry per frame_tick pulse.
  always @(negedge clk_pix) begin
    exp_t e;
    if (mon_en && frame_tick === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame_tick actual=1 expected=0");
      end else begin
        e = sb.pop_front();
        if (e.chk) begin
          check("cat_x", 32'(cat_x), e.x);
          check("cat_y", 32'(cat_y), e.y);
          check("dir", 32'(dir), e.dir);
          check("frame_idx", 32'(frame_idx), e.frame);
          check("airborne", 32'(airborne), e.air);
        end
      end
    end
  end

  initial begin
    int pulses;

    // Reset state.
    repeat (3) @(negedge clk_pix);
    rst_pix_n = 1'b1;
    mon_en    = 1'b1;
    repeat (2) @(negedge clk_pix);
    check("reset cat_x", 32'(cat_x), 272);
    check("reset cat_y", 32'(cat_y), 220);
    check("reset dir", 32'(dir), 1);
    check("reset frame_idx", 32'(frame_idx), 0);
    check("reset airborne", 32'(airborne), 0);
    check("reset frame_tick", 32'(frame_tick), 0);

    // Walk, right bounce, left bounce.
    for (int k = 1; k <= 473; k++) begin
      if (k == 1)        tick(1'b1, 274, 220, 1, 0, 0);
      else if (k == 8)   tick(1'b1, 288, 220, 1, 1, 0);
      else if (k == 168) tick(1'b1, 608, 220, 0, 1, 0);
      else if (k == 169) tick(1'b1, 606, 220, 0, 1, 0);
      else if (k == 471) tick(1'b1, 2, 220, 0, 2, 0);
      else if (k == 472) tick(1'b1, 0, 220, 1, 3, 0);
      else if (k == 473) tick(1'b1, 2, 220, 1, 3, 0);
      else               tick_nc();
    end
    drain("patrol");

    // Jump from WALK, with a second press during RISE that must be discarded.
    press();
    for (int k = 1; k <= 21; k++) begin
      if (k == 1)       tick(1'b1, 4, 216, 1, 3, 1);
      else if (k == 2)  tick(1'b1, 6, 212, 1, 3, 1);
      else if (k == 10) tick(1'b1, 22, 180, 1, 3, 1);
      else if (k == 11) tick(1'b1, 24, 184, 1, 3, 1);
      else if (k == 20) tick(1'b1, 42, 220, 1, 3, 0);
      else if (k == 21) tick(1'b1, 44, 220, 1, 3, 0);
      else              tick_nc();
      if (k == 2) press();
    end
    drain("jump");

    // Pause with a latched jump: five frozen pulses, then the jump starts.
    press();
    pause = 1'b1;
    repeat (5) tick(1'b1, 44, 220, 1, 3, 0);
    drain("pause");
    pause = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      if (k == 1)       tick(1'b1, 46, 216, 1, 3, 1);
      else if (k == 11) tick(1'b1, 66, 184, 1, 3, 1);
      else              tick_nc();
    end
    drain("resume");

    // Asynchronous reset mid-FALL, checked between clock edges.
    @(negedge clk_pix);
    #2 rst_pix_n = 1'b0;
    #1;
    check("async rst cat_x", 32'(cat_x), 272);
    check("async rst cat_y", 32'(cat_y), 220);
    check("async rst dir", 32'(dir), 1);
    check("async rst frame_idx", 32'(frame_idx), 0);
    check("async rst airborne", 32'(airborne), 0);
    check("async rst frame_tick", 32'(frame_tick), 0);
    repeat (2) @(negedge clk_pix);
    rst_pix_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_pix);
      if (frame_tick === 1'b1) pulses++;
    end
    check("no pulse after reset", 32'(pulses), 0);
    tick(1'b1, 274, 220, 1, 0, 0);
    drain("post reset");

    // A press whose edge coincides with the tick edge is dropped.
    @(negedge clk_pix);
    btn_jump = 1'b1;
    @(negedge clk_pix);
    @(negedge clk_pix);
    sx = 10'd0;
    sy = 9'd480;
    sb.push_back('{chk: 1'b1, x: 276, y: 220, dir: 1, frame: 0, air: 0});
    @(negedge clk_pix);
    sx = 10'd5;
    sy = 9'd100;
    btn_jump = 1'b0;
    repeat (4) @(negedge clk_pix);
    tick(1'b1, 278, 220, 1, 0, 0);
    drain("dropped press");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
